// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction-fetch stage of the pipelined core. Owns the program counter and
// the IF/ID pipeline register. The PC is presented directly to a
// combinational-read instruction ROM. The returned big-endian word is
// registered for the decode stage together with its PC+4.
//
// Stalls, taken-branch redirects with wrong-path squash, and detection of
// misaligned or out-of-range fetch addresses are handled here.
//
// Optional feature (compile-time macro FETCH_HALT_DETECT_EN):
//   Detects a jump-to-self instruction (opcode 6'b101010, offset 16'hFFFF) on
//   a sequential fetch. The PC freezes, halted_o rises, and the stage parks
//   in HALT until reset. Without the macro, halted_o is tied low.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   MEM_BYTES  ROM size in bytes; a fetch at pc is legal only if pc+3 < MEM_BYTES
//
// Ports:
//   clock               rising-edge clock
//   reset               asynchronous active-low reset (0 = reset)
//   stall_i             decode hazard stall: hold PC and IF/ID
//   branch_taken_i      redirect request from decode
//   branch_target_i     redirect byte address
//   rom_address_o       byte address to the ROM (the PC register)
//   rom_instruction_i   ROM read data for rom_address_o, same cycle
//   ifid_instruction_o  registered instruction to decode
//   ifid_pc_plus4_o     registered PC+4 of that instruction
//   ifid_valid_o        IF/ID holds a real, non-squashed instruction
//   fetch_fault_o       sticky misaligned / out-of-range fetch fault
//   halted_o            self-loop halt detected (0 without the feature)
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 404
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] rom_address_o,
  input  logic [31:0] rom_instruction_i,
  output logic [31:0] ifid_instruction_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        ifid_valid_o,
  output logic        fetch_fault_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP       = 32'd0;
  // Widened by one bit so that address+3 cannot wrap around 2^32 and slip
  // under the range limit.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  fetch_state_e state, state_next;

  logic [31:0] pc, pc_next;
  logic [31:0] instruction, instruction_next;
  logic [31:0] pc_plus4_reg, pc_plus4_next;
  logic        valid, valid_next;
  logic        fault, fault_next;

  logic [31:0] pc_plus4;
  logic        pc_bad;
  logic        target_bad;

  // A fetch is legal only when word-aligned and all four bytes lie in the ROM.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    return (addr[1:0] != 2'b00) || (last_byte >= MEM_LIMIT);
  endfunction

  assign pc_plus4   = pc + 32'd4;
  assign pc_bad     = addr_bad(pc);
  assign target_bad = addr_bad(branch_target_i);

`ifdef FETCH_HALT_DETECT_EN
  logic halted, halted_next;
  logic self_jump;

  assign self_jump = (rom_instruction_i[31:26] == 6'b101010) &&
                     (rom_instruction_i[15:0]  == 16'hFFFF);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a hold value before any branch of the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    state_next       = state;
    pc_next          = pc;
    instruction_next = instruction;
    pc_plus4_next    = pc_plus4_reg;
    valid_next       = valid;
    fault_next       = fault;
`ifdef FETCH_HALT_DETECT_EN
    halted_next      = halted;
`endif

    unique case (state)
      RUN: begin
        if (branch_taken_i) begin
          // A redirect wins over stall. The word currently in flight is
          // from the wrong path, so the slot is squashed.
          pc_next          = branch_target_i;
          instruction_next = NOP;
          pc_plus4_next    = 32'd0;
          valid_next       = 1'b0;
          if (target_bad) begin
            fault_next = 1'b1;
            state_next = FAULT;
          end
        end else if (pc_bad) begin
          // The ROM word for an illegal address is never captured.
          instruction_next = NOP;
          pc_plus4_next    = 32'd0;
          valid_next       = 1'b0;
          fault_next       = 1'b1;
          state_next       = FAULT;
        end else if (stall_i) begin
          // Hold everything; the defaults already do that.
        end else begin
          instruction_next = rom_instruction_i;
          pc_plus4_next    = pc_plus4;
          valid_next       = 1'b1;
          pc_next          = pc_plus4;
`ifdef FETCH_HALT_DETECT_EN
          // The self-jump itself still reaches decode. Only the PC stops.
          if (self_jump) begin
            pc_next     = pc;
            halted_next = 1'b1;
            state_next  = HALT;
          end
`endif
        end
      end

      FAULT, HALT: begin
        // Terminal states: PC frozen, decode fed bubbles until reset.
        instruction_next = NOP;
        pc_plus4_next    = 32'd0;
        valid_next       = 1'b0;
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      instruction  <= NOP;
      pc_plus4_reg <= 32'd0;
      valid        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values computed above regardless of statement order.
      state        <= state_next;
      pc           <= pc_next;
      instruction  <= instruction_next;
      pc_plus4_reg <= pc_plus4_next;
      valid        <= valid_next;
      fault        <= fault_next;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else begin
      halted <= halted_next;
    end
  end

  assign halted_o = halted;
`else
  assign halted_o = 1'b0;
`endif

  assign rom_address_o      = pc;
  assign ifid_instruction_o = instruction;
  assign ifid_pc_plus4_o    = pc_plus4_reg;
  assign ifid_valid_o       = valid;
  assign fetch_fault_o      = fault;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Directed bench for instr_fetch_stage. A small behavioural ROM answers the
// DUT's address combinationally. Word 0 is 32'h8001060A, word 380 is the
// self-jump 32'hA800FFFF, and every other word is {16'hC0DE, addr[15:0]}.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] rom_address_o;
  logic [31:0] rom_instruction_i;
  logic [31:0] ifid_instruction_o;
  logic [31:0] ifid_pc_plus4_o;
  logic        ifid_valid_o;
  logic        fetch_fault_o;
  logic        halted_o;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_stage #(
    .RESET_PC  (32'd0),
    .MEM_BYTES (404)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .stall_i            (stall_i),
    .branch_taken_i     (branch_taken_i),
    .branch_target_i    (branch_target_i),
    .rom_address_o      (rom_address_o),
    .rom_instruction_i  (rom_instruction_i),
    .ifid_instruction_o (ifid_instruction_o),
    .ifid_pc_plus4_o    (ifid_pc_plus4_o),
    .ifid_valid_o       (ifid_valid_o),
    .fetch_fault_o      (fetch_fault_o),
    .halted_o           (halted_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr == 32'd0)        return 32'h8001060A;
    else if (addr == 32'd380) return 32'hA800FFFF;
    else                      return {16'hC0DE, addr[15:0]};
  endfunction

  always_comb rom_instruction_i = rom_word(rom_address_o);

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Assert reset away from any edge, then release it 1 unit after an edge.
  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset           = 1'b0;
    stall_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'd0;

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    #1;
    check("reset_pc",     rom_address_o,            32'd0);
    check("reset_instr",  ifid_instruction_o,       32'd0);
    check("reset_pc4",    ifid_pc_plus4_o,          32'd0);
    check("reset_valid",  32'(ifid_valid_o),        32'd0);
    check("reset_fault",  32'(fetch_fault_o),       32'd0);
    check("reset_halted", 32'(halted_o),            32'd0);

    // First edge after release fetches address 0.
    reset = 1'b1;
    step();
    check("first_instr", ifid_instruction_o, 32'h8001060A);
    check("first_pc4",   ifid_pc_plus4_o,    32'd4);
    check("first_valid", 32'(ifid_valid_o),  32'd1);
    check("first_pc",    rom_address_o,      32'd4);

    // Sequential run up to PC=28. IF/ID pc_plus4 equals the new PC.
    for (int a = 8; a <= 28; a += 4) begin
      step();
      check("seq_pc",    rom_address_o,      32'(a));
      check("seq_pc4",   ifid_pc_plus4_o,    32'(a));
      check("seq_instr", ifid_instruction_o, rom_word(32'(a - 4)));
      check("seq_valid", 32'(ifid_valid_o),  32'd1);
    end

    // Two stalled edges at PC=28 hold everything.
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc",    rom_address_o,      32'd28);
      check("stall_instr", ifid_instruction_o, rom_word(32'd24));
      check("stall_pc4",   ifid_pc_plus4_o,    32'd28);
      check("stall_valid", 32'(ifid_valid_o),  32'd1);
    end
    stall_i = 1'b0;
    step();
    check("unstall_instr", ifid_instruction_o, rom_word(32'd28));
    check("unstall_pc4",   ifid_pc_plus4_o,    32'd32);
    check("unstall_pc",    rom_address_o,      32'd32);

    // Advance to PC=100.
    repeat (17) step();
    check("adv_pc", rom_address_o, 32'd100);

    // Branch with a simultaneous stall: the branch wins and the slot is squashed.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'd92;
    stall_i         = 1'b1;
    step();
    branch_taken_i = 1'b0;
    stall_i        = 1'b0;
    check("br_pc",    rom_address_o,      32'd92);
    check("br_instr", ifid_instruction_o, 32'd0);
    check("br_pc4",   ifid_pc_plus4_o,    32'd0);
    check("br_valid", 32'(ifid_valid_o),  32'd0);
    step();
    check("br_next_instr", ifid_instruction_o, rom_word(32'd92));
    check("br_next_pc4",   ifid_pc_plus4_o,    32'd96);
    check("br_next_valid", 32'(ifid_valid_o),  32'd1);

    // Upper boundary: 400 is the last legal word; 404 faults.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'd396;
    step();
    branch_taken_i = 1'b0;
    check("edge_fault_396", 32'(fetch_fault_o), 32'd0);
    step();
    step();
    check("edge_instr_400", ifid_instruction_o, rom_word(32'd400));
    check("edge_pc4_400",   ifid_pc_plus4_o,    32'd404);
    check("edge_valid_400", 32'(ifid_valid_o),  32'd1);
    check("edge_fault_400", 32'(fetch_fault_o), 32'd0);
    check("edge_pc_404",    rom_address_o,      32'd404);
    step();
    check("oor_fault", 32'(fetch_fault_o),  32'd1);
    check("oor_valid", 32'(ifid_valid_o),   32'd0);
    check("oor_instr", ifid_instruction_o,  32'd0);
    check("oor_pc",    rom_address_o,       32'd404);

    // Asynchronous reset clears state without an edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_pc",    rom_address_o,     32'd0);
    check("async_fault", 32'(fetch_fault_o), 32'd0);
    check("async_valid", 32'(ifid_valid_o),  32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    check("resume_instr", ifid_instruction_o, 32'h8001060A);
    check("resume_pc",    rom_address_o,      32'd4);

    // Branch to 402: out of range, PC loads the target and freezes.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'd402;
    step();
    check("t402_fault", 32'(fetch_fault_o), 32'd1);
    check("t402_valid", 32'(ifid_valid_o),  32'd0);
    check("t402_pc",    rom_address_o,      32'd402);
    branch_target_i = 32'd0;  // FAULT ignores further redirects
    step();
    branch_taken_i = 1'b0;
    check("t402_frozen_pc", rom_address_o,      32'd402);
    check("t402_sticky",    32'(fetch_fault_o), 32'd1);

    // Misaligned target 401.
    pulse_reset();
    check("t401_cleared", 32'(fetch_fault_o), 32'd0);
    branch_taken_i  = 1'b1;
    branch_target_i = 32'd401;
    step();
    branch_taken_i = 1'b0;
    check("t401_fault", 32'(fetch_fault_o), 32'd1);
    check("t401_valid", 32'(ifid_valid_o),  32'd0);
    step();
    check("t401_frozen_pc", rom_address_o, 32'd401);

    // Target whose +3 wraps past 2^32 must still be caught.
    pulse_reset();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    step();
    branch_taken_i = 1'b0;
    check("wrap_fault", 32'(fetch_fault_o), 32'd1);
    check("wrap_pc",    rom_address_o,      32'hFFFF_FFFC);

    // Reset clears the fault and fetch resumes at 0.
    pulse_reset();
    check("clr_fault", 32'(fetch_fault_o), 32'd0);
    step();
    check("clr_instr", ifid_instruction_o, 32'h8001060A);
    check("clr_valid", 32'(ifid_valid_o),  32'd1);

    // Self-jump at 380.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'd380;
    step();
    branch_taken_i = 1'b0;
    check("sj_pc", rom_address_o, 32'd380);
    step();
    check("sj_instr", ifid_instruction_o, 32'hA800FFFF);
    check("sj_valid", 32'(ifid_valid_o),  32'd1);
    check("sj_pc4",   ifid_pc_plus4_o,    32'd384);
`ifdef FETCH_HALT_DETECT_EN
    check("halt_flag", 32'(halted_o),    32'd1);
    check("halt_pc",   rom_address_o,    32'd380);
    branch_taken_i  = 1'b1;  // HALT ignores redirects and stalls
    branch_target_i = 32'd0;
    stall_i         = 1'b1;
    step();
    check("halt_valid2", 32'(ifid_valid_o),  32'd0);
    check("halt_instr2", ifid_instruction_o, 32'd0);
    check("halt_pc2",    rom_address_o,      32'd380);
    check("halt_flag2",  32'(halted_o),      32'd1);
    branch_taken_i = 1'b0;
    stall_i        = 1'b0;
    pulse_reset();
    check("halt_cleared", 32'(halted_o), 32'd0);
`else
    check("nohalt_flag", 32'(halted_o), 32'd0);
    check("nohalt_pc",   rom_address_o, 32'd384);
    step();
    check("nohalt_instr", ifid_instruction_o, rom_word(32'd384));
    check("nohalt_valid", 32'(ifid_valid_o),  32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
